// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and default register widths used by the
// operand loader and the ALU it feeds.
package alu_pkg;

    localparam int unsigned NB_OPERANDO_DEF = 8;
    localparam int unsigned NB_OPCODE_DEF   = 6;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

endpackage

// File: rtl/alu_input_loader_btn_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, saturating stability counter and a
// combinational pulse on the edge where the debounced level rises.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NB_DEB_CNT      = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [NB_DEB_CNT-1:0] CNT_MAX = NB_DEB_CNT'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            sync_q;
    logic                  level_q, level_d;
    logic [NB_DEB_CNT-1:0] cnt_q, cnt_d;
    logic                  differs;
    logic                  toggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // The toggle edge is exposed directly so the load happens on the same edge.
    always_comb begin
        differs = (sync_q[1] != level_q);
        toggle  = differs && (cnt_q == CNT_MAX);
        level_d = level_q;
        cnt_d   = '0;
        if (toggle) begin
            level_d = ~level_q;
        end else if (differs) begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_o = toggle & ~level_q;
    end

endmodule

// File: rtl/alu_input_loader.sv
// Latches the switch bank into operand A, operand B and opcode registers on debounced
// button presses; reports load events and when all three registers hold data.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int unsigned NB_SW           = 8,
    parameter int unsigned NB_OPERANDO     = NB_OPERANDO_DEF,
    parameter int unsigned NB_OPCODE       = NB_OPCODE_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned NB_DEB_CNT      = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB_SW-1:0]       sw,
    input  logic                   btn_a,
    input  logic                   btn_b,
    input  logic                   btn_op,
    output logic [NB_OPERANDO-1:0] dato_a,
    output logic [NB_OPERANDO-1:0] dato_b,
    output logic [NB_OPCODE-1:0]   opcode,
    output logic                   load_strobe,
    output logic                   operands_valid
);

    logic [NB_SW-1:0]       sw_meta_q, sw_sync_q;
    logic                   rise_a, rise_b, rise_op;
    logic [NB_OPERANDO-1:0] dato_a_q, dato_a_d;
    logic [NB_OPERANDO-1:0] dato_b_q, dato_b_d;
    logic [NB_OPCODE-1:0]   opcode_q, opcode_d;
    logic [2:0]             loaded_q, loaded_d;
    logic                   strobe_q, strobe_d;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DEB_CNT(NB_DEB_CNT)) u_deb_a (
        .clk(clk), .rst(rst), .btn_i(btn_a), .rise_o(rise_a)
    );
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DEB_CNT(NB_DEB_CNT)) u_deb_b (
        .clk(clk), .rst(rst), .btn_i(btn_b), .rise_o(rise_b)
    );
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DEB_CNT(NB_DEB_CNT)) u_deb_op (
        .clk(clk), .rst(rst), .btn_i(btn_op), .rise_o(rise_op)
    );

    always_comb begin
        dato_a_d = dato_a_q;
        dato_b_d = dato_b_q;
        opcode_d = opcode_q;
        if (rise_a)  dato_a_d = sw_sync_q[NB_OPERANDO-1:0];
        if (rise_b)  dato_b_d = sw_sync_q[NB_OPERANDO-1:0];
        if (rise_op) opcode_d = sw_sync_q[NB_OPCODE-1:0];
        loaded_d = loaded_q | {rise_op, rise_b, rise_a};
        strobe_d = rise_a | rise_b | rise_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            dato_a_q  <= '0;
            dato_b_q  <= '0;
            opcode_q  <= '0;
            loaded_q  <= '0;
            strobe_q  <= 1'b0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            dato_a_q  <= dato_a_d;
            dato_b_q  <= dato_b_d;
            opcode_q  <= opcode_d;
            loaded_q  <= loaded_d;
            strobe_q  <= strobe_d;
        end
    end

    assign dato_a         = dato_a_q;
    assign dato_b         = dato_b_q;
    assign opcode         = opcode_q;
    assign load_strobe    = strobe_q;
    assign operands_valid = &loaded_q;

endmodule
